// File: rtl/desc_norm_buffer.sv
// Buffers one tlast-delimited int8 descriptor while summing lane squares, requests its rsqrt, then replays the beats.
// Replay output is registered (first beat 1 cycle after the rsqrt arrives); input is accepted only while idle in ACCUM.
module desc_norm_buffer #(
    parameter int BEATS = 32,
    parameter int SUM_W = 24,
    parameter int RSQ_W = 24
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [63:0]      s_axis_raw_tdata,
    input  logic             s_axis_raw_tvalid,
    input  logic             s_axis_raw_tlast,
    output logic             s_axis_raw_tready,
    output logic [SUM_W-1:0] m_axis_sumsq_tdata,
    output logic             m_axis_sumsq_tvalid,
    input  logic             m_axis_sumsq_tready,
    input  logic [RSQ_W-1:0] s_axis_rsq_tdata,
    input  logic             s_axis_rsq_tvalid,
    output logic             s_axis_rsq_tready,
    output logic [RSQ_W-1:0] reciprocal_squa_root,
    output logic [63:0]      m_axis_desc_tdata,
    output logic             m_axis_desc_tvalid,
    output logic             m_axis_desc_tlast,
    input  logic             m_axis_desc_tready,
    output logic             len_err
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {ACCUM, REQ, WAIT, REPLAY} state_t;

    state_t           state;
    logic [63:0]      buffer [BEATS];
    logic [CNT_W-1:0] wr_cnt;
    logic [CNT_W-1:0] rd_cnt;
    logic [CNT_W-1:0] last_idx;
    logic [SUM_W-1:0] acc;
    logic [SUM_W-1:0] acc_next;
    logic [17:0]      beat_sq;
    logic             raw_fire;
    logic             end_pkt;
    logic             replay_adv;

    function automatic logic [15:0] sq8(input logic [7:0] v);
        logic signed [15:0] p;
        p = $signed(v) * $signed(v);
        return p;
    endfunction

    // Each square is at most 16384, so eight of them fit in 18 bits.
    always_comb begin
        beat_sq = '0;
        for (int i = 0; i < 8; i++) begin
            beat_sq = beat_sq + 18'(sq8(s_axis_raw_tdata[8*i +: 8]));
        end
    end

    assign acc_next          = acc + SUM_W'(beat_sq);
    assign s_axis_raw_tready = (state == ACCUM);
    assign s_axis_rsq_tready = (state == WAIT);
    assign raw_fire          = s_axis_raw_tvalid && s_axis_raw_tready;
    assign end_pkt           = s_axis_raw_tlast || (wr_cnt == CNT_W'(BEATS - 1));
    assign replay_adv        = !m_axis_desc_tvalid || m_axis_desc_tready;

    // Packet storage carries no reset so it can map onto a plain RAM.
    always_ff @(posedge clk) begin
        if (raw_fire) begin
            buffer[wr_cnt] <= s_axis_raw_tdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state                <= ACCUM;
            wr_cnt               <= '0;
            rd_cnt               <= '0;
            last_idx             <= '0;
            acc                  <= '0;
            len_err              <= 1'b0;
            m_axis_sumsq_tdata   <= '0;
            m_axis_sumsq_tvalid  <= 1'b0;
            reciprocal_squa_root <= '0;
            m_axis_desc_tdata    <= '0;
            m_axis_desc_tvalid   <= 1'b0;
            m_axis_desc_tlast    <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (raw_fire) begin
                        wr_cnt <= wr_cnt + CNT_W'(1);
                        acc    <= acc_next;
                        if (end_pkt) begin
                            m_axis_sumsq_tdata  <= acc_next;
                            m_axis_sumsq_tvalid <= 1'b1;
                            last_idx            <= wr_cnt;
                            if (!s_axis_raw_tlast) begin
                                len_err <= 1'b1;
                            end
                            state <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (m_axis_sumsq_tready) begin
                        m_axis_sumsq_tvalid <= 1'b0;
                        state               <= WAIT;
                    end
                end
                WAIT: begin
                    if (s_axis_rsq_tvalid) begin
                        reciprocal_squa_root <= s_axis_rsq_tdata;
                        rd_cnt               <= '0;
                        state                <= REPLAY;
                    end
                end
                REPLAY: begin
                    if (replay_adv) begin
                        if (m_axis_desc_tvalid && m_axis_desc_tlast) begin
                            // Final beat leaves this edge; reopen input next cycle.
                            m_axis_desc_tvalid <= 1'b0;
                            m_axis_desc_tlast  <= 1'b0;
                            acc                <= '0;
                            wr_cnt             <= '0;
                            state              <= ACCUM;
                        end else begin
                            m_axis_desc_tdata  <= buffer[rd_cnt];
                            m_axis_desc_tvalid <= 1'b1;
                            m_axis_desc_tlast  <= (rd_cnt == last_idx);
                            rd_cnt             <= rd_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_desc_norm_buffer.sv
// Directed packet table plus reset, backpressure and delayed-rsqrt sequences for desc_norm_buffer.
module tb_desc_norm_buffer;

    logic        clk;
    logic        rstn;
    logic [63:0] s_axis_raw_tdata;
    logic        s_axis_raw_tvalid;
    logic        s_axis_raw_tlast;
    logic        s_axis_raw_tready;
    logic [23:0] m_axis_sumsq_tdata;
    logic        m_axis_sumsq_tvalid;
    logic        m_axis_sumsq_tready;
    logic [23:0] s_axis_rsq_tdata;
    logic        s_axis_rsq_tvalid;
    logic        s_axis_rsq_tready;
    logic [23:0] reciprocal_squa_root;
    logic [63:0] m_axis_desc_tdata;
    logic        m_axis_desc_tvalid;
    logic        m_axis_desc_tlast;
    logic        m_axis_desc_tready;
    logic        len_err;

    int checks = 0;
    int errors = 0;

    desc_norm_buffer #(.BEATS(32), .SUM_W(24), .RSQ_W(24)) dut (
        .clk                  (clk),
        .rstn                 (rstn),
        .s_axis_raw_tdata     (s_axis_raw_tdata),
        .s_axis_raw_tvalid    (s_axis_raw_tvalid),
        .s_axis_raw_tlast     (s_axis_raw_tlast),
        .s_axis_raw_tready    (s_axis_raw_tready),
        .m_axis_sumsq_tdata   (m_axis_sumsq_tdata),
        .m_axis_sumsq_tvalid  (m_axis_sumsq_tvalid),
        .m_axis_sumsq_tready  (m_axis_sumsq_tready),
        .s_axis_rsq_tdata     (s_axis_rsq_tdata),
        .s_axis_rsq_tvalid    (s_axis_rsq_tvalid),
        .s_axis_rsq_tready    (s_axis_rsq_tready),
        .reciprocal_squa_root (reciprocal_squa_root),
        .m_axis_desc_tdata    (m_axis_desc_tdata),
        .m_axis_desc_tvalid   (m_axis_desc_tvalid),
        .m_axis_desc_tlast    (m_axis_desc_tlast),
        .m_axis_desc_tready   (m_axis_desc_tready),
        .len_err              (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          pat;
        int          nbeats;
        bit          tlast;
        logic [23:0] rsq;
        logic [23:0] sum;
        bit          lerr;
        int          stall;
        int          rdly;
        bit          rnd;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] gen_beat(input int pat, input int idx);
        logic [7:0] b;
        case (pat)
            0: return 64'h8080808080808080;
            1: return (idx == 0) ? 64'h0807060504030201 : 64'hF8F9FAFBFCFDFEFF;
            3: begin
                b = idx[7:0];
                return {8{b}};
            end
            default: return 64'h0;
        endcase
    endfunction

    task automatic send_beat(input logic [63:0] d, input bit last);
        int n;
        n = 0;
        s_axis_raw_tdata  = d;
        s_axis_raw_tlast  = last;
        s_axis_raw_tvalid = 1'b1;
        while (!s_axis_raw_tready && n < 200) begin
            tick();
            n++;
        end
        if (!s_axis_raw_tready) chk("raw_ready_timeout", 0, 1);
        tick();
        s_axis_raw_tvalid = 1'b0;
        s_axis_raw_tlast  = 1'b0;
    endtask

    task automatic run_packet(input vec_t v, input string tag);
        int n;
        int bad;
        int got;
        int data_bad;
        int last_bad;
        int rsq_bad;
        int hold_bad;
        bit holding;
        logic [63:0] hold_d;
        logic        hold_l;
        logic [23:0] sum_seen;

        for (int i = 0; i < v.nbeats; i++) begin
            send_beat(gen_beat(v.pat, i), v.tlast && (i == v.nbeats - 1));
        end

        n = 0;
        while (!m_axis_sumsq_tvalid && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_sum_valid"}, m_axis_sumsq_tvalid, 1);
        chk({tag, "_sum"}, m_axis_sumsq_tdata, v.sum);

        bad = 0;
        sum_seen = m_axis_sumsq_tdata;
        for (int i = 0; i < v.stall; i++) begin
            tick();
            if (!m_axis_sumsq_tvalid || m_axis_sumsq_tdata !== sum_seen || s_axis_raw_tready) bad++;
        end
        if (v.stall > 0) chk({tag, "_sum_stall_hold"}, bad, 0);

        m_axis_sumsq_tready = 1'b1;
        tick();
        m_axis_sumsq_tready = 1'b0;
        chk({tag, "_sum_drop"}, m_axis_sumsq_tvalid, 0);

        bad = 0;
        for (int i = 0; i < v.rdly; i++) begin
            tick();
            if (s_axis_raw_tready || m_axis_desc_tvalid) bad++;
        end
        if (v.rdly > 0) chk({tag, "_raw_ready_low"}, bad, 0);

        s_axis_rsq_tdata  = v.rsq;
        s_axis_rsq_tvalid = 1'b1;
        n = 0;
        while (!s_axis_rsq_tready && n < 100) begin
            tick();
            n++;
        end
        if (!s_axis_rsq_tready) chk({tag, "_rsq_ready_timeout"}, 0, 1);
        tick();
        s_axis_rsq_tvalid = 1'b0;
        s_axis_rsq_tdata  = 24'h0;
        chk({tag, "_rsq_latched"}, reciprocal_squa_root, v.rsq);
        chk({tag, "_no_early_valid"}, m_axis_desc_tvalid, 0);
        tick();
        chk({tag, "_first_valid"}, m_axis_desc_tvalid, 1);

        got = 0; data_bad = 0; last_bad = 0; rsq_bad = 0; hold_bad = 0;
        holding = 1'b0; hold_d = '0; hold_l = 1'b0;
        n = 0;
        while (got < v.nbeats && n < 2000) begin
            if (holding && (!m_axis_desc_tvalid || m_axis_desc_tdata !== hold_d ||
                            m_axis_desc_tlast !== hold_l)) hold_bad++;
            m_axis_desc_tready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            holding = 1'b0;
            if (reciprocal_squa_root !== v.rsq) rsq_bad++;
            if (m_axis_desc_tvalid && m_axis_desc_tready) begin
                if (m_axis_desc_tdata !== gen_beat(v.pat, got)) data_bad++;
                if (m_axis_desc_tlast !== (got == v.nbeats - 1)) last_bad++;
                got++;
            end else if (m_axis_desc_tvalid) begin
                holding = 1'b1;
                hold_d  = m_axis_desc_tdata;
                hold_l  = m_axis_desc_tlast;
            end
            tick();
            n++;
        end
        m_axis_desc_tready = 1'b0;
        chk({tag, "_beat_count"}, got, v.nbeats);
        chk({tag, "_replay_data"}, data_bad, 0);
        chk({tag, "_replay_tlast"}, last_bad, 0);
        chk({tag, "_rsq_held"}, rsq_bad, 0);
        chk({tag, "_stall_hold"}, hold_bad, 0);
        chk({tag, "_raw_ready_back"}, s_axis_raw_tready, 1);
        chk({tag, "_desc_valid_drop"}, m_axis_desc_tvalid, 0);
        chk({tag, "_len_err"}, len_err, v.lerr);
    endtask

    initial begin
        tbl[0] = '{pat: 0, nbeats: 32, tlast: 1, rsq: 24'h000400, sum: 24'd4194304, lerr: 0, stall: 5, rdly: 0, rnd: 0};
        tbl[1] = '{pat: 1, nbeats: 2,  tlast: 1, rsq: 24'h123456, sum: 24'd408,     lerr: 0, stall: 0, rdly: 20, rnd: 0};
        tbl[2] = '{pat: 4, nbeats: 3,  tlast: 1, rsq: 24'hFFFFFF, sum: 24'd0,       lerr: 0, stall: 0, rdly: 20, rnd: 1};
        tbl[3] = '{pat: 3, nbeats: 32, tlast: 0, rsq: 24'h000001, sum: 24'd83328,   lerr: 1, stall: 2, rdly: 3, rnd: 1};
        tbl[4] = '{pat: 1, nbeats: 1,  tlast: 1, rsq: 24'h0000AA, sum: 24'd204,     lerr: 1, stall: 0, rdly: 0, rnd: 0};
        tbl[5] = '{pat: 0, nbeats: 4,  tlast: 1, rsq: 24'h00BEEF, sum: 24'd524288,  lerr: 1, stall: 1, rdly: 1, rnd: 1};

        rstn = 1'b0;
        s_axis_raw_tdata = '0; s_axis_raw_tvalid = 1'b0; s_axis_raw_tlast = 1'b0;
        m_axis_sumsq_tready = 1'b0;
        s_axis_rsq_tdata = '0; s_axis_rsq_tvalid = 1'b0;
        m_axis_desc_tready = 1'b0;
        repeat (3) tick();
        rstn = 1'b1;
        tick();
        chk("rst_raw_ready", s_axis_raw_tready, 1);
        chk("rst_sum_valid", m_axis_sumsq_tvalid, 0);
        chk("rst_desc_valid", m_axis_desc_tvalid, 0);
        chk("rst_rsq_ready", s_axis_rsq_tready, 0);
        chk("rst_recip", reciprocal_squa_root, 0);
        chk("rst_len_err", len_err, 0);

        // Abort a partial packet with an asynchronous reset.
        for (int i = 0; i < 10; i++) send_beat(gen_beat(3, i), 1'b0);
        #2 rstn = 1'b0;
        #1;
        chk("midrst_sum_valid", m_axis_sumsq_tvalid, 0);
        chk("midrst_sum_data", m_axis_sumsq_tdata, 0);
        chk("midrst_desc_data", m_axis_desc_tdata, 0);
        tick();
        rstn = 1'b1;
        tick();
        chk("midrst_raw_ready", s_axis_raw_tready, 1);

        for (int k = 0; k < 6; k++) begin
            run_packet(tbl[k], $sformatf("pkt%0d", k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
